// File: rtl/execute_stage_pipe.sv
// Execute stage between decode and data memory.
// Single-cycle ALU ops and branch/jump resolution load the output register directly.
// MULT/MULTU/DIVU iterate one bit per cycle into the internal HI/LO pair.
// A valid/ready register on the output lets the stage stall under backpressure.
module execute_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4:0]                in_op,
    input  logic [DATA_W-1:0]         in_a,
    input  logic [DATA_W-1:0]         in_b,
    input  logic [$clog2(DATA_W)-1:0] in_shamt,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [PC_W-1:0]           in_pc4,
    input  logic [1:0]                in_branch,
    input  logic                      in_jump,
    input  logic [25:0]               in_jindex,
    input  logic [REG_ADDR_W-1:0]     in_rw,
    input  logic                      in_reg_write,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_result,
    output logic [REG_ADDR_W-1:0]     out_rw,
    output logic                      out_reg_write,
    output logic                      out_zero,
    output logic                      out_ovf,
    output logic                      redirect,
    output logic [PC_W-1:0]           redirect_pc,
    output logic                      busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]   ONE_W     = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [2*DATA_W-1:0] ONE_2W    = {{(2*DATA_W-1){1'b0}}, 1'b1};

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
    localparam logic [4:0] OP_MULT  = 5'd12;
    localparam logic [4:0] OP_MULTU = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2*DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]       opnd_q, opnd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    neg_q, neg_d;
    logic [DATA_W-1:0]       hi_q, hi_d, lo_q, lo_d;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_W-1:0]       result_q, result_d;
    logic [REG_ADDR_W-1:0]   rw_q, rw_d;
    logic                    reg_write_q, reg_write_d;
    logic                    zero_q, zero_d;
    logic                    ovf_q, ovf_d;
    logic                    redirect_q, redirect_d;
    logic [PC_W-1:0]         redirect_pc_q, redirect_pc_d;

    logic                    out_free_s, xfer_s;
    logic [DATA_W-1:0]       sub_b_s, add_sum_s, sub_diff_s, mag_a_s, mag_b_s;
    logic [PC_W-1:0]         imm_pc_s, br_target_s, jmp_target_s;
    logic                    br_active_s, br_taken_s, is_multi_s;
    logic [DATA_W-1:0]       alu_result_s;
    logic                    alu_ovf_s, alu_write_s, redir_s;
    logic [PC_W-1:0]         redir_pc_s;
    logic [DATA_W:0]         mul_sum_s;
    logic [DATA_W+1:0]       div_trial_s;
    logic [2*DATA_W-1:0]     prod_s;

    // Output register is free when empty or being drained this cycle.
    assign out_free_s   = ~out_valid_q | out_ready;
    assign in_ready     = RST_N & (state_q == S_IDLE) & out_free_s;
    assign xfer_s       = in_valid & in_ready;

    assign sub_b_s      = ~in_b + ONE_W;
    assign add_sum_s    = in_a + in_b;
    assign sub_diff_s   = in_a + sub_b_s;

    assign imm_pc_s     = PC_W'($signed(in_imm));
    assign br_target_s  = in_pc4 + {imm_pc_s[PC_W-3:0], 2'b00};
    assign jmp_target_s = {in_pc4[PC_W-1:28], in_jindex, 2'b00};
    assign br_active_s  = (in_branch == 2'b01) | (in_branch == 2'b10);
    assign br_taken_s   = ((in_branch == 2'b01) & (in_a == in_b)) |
                          ((in_branch == 2'b10) & (in_a != in_b));
    assign is_multi_s   = ~in_jump & ~br_active_s &
                          ((in_op == OP_MULT) | (in_op == OP_MULTU) | (in_op == OP_DIVU));

    // Signed multiply works on magnitudes; the sign is reapplied at completion.
    assign mag_a_s      = ((in_op == OP_MULT) & in_a[DATA_W-1]) ? (~in_a + ONE_W) : in_a;
    assign mag_b_s      = ((in_op == OP_MULT) & in_b[DATA_W-1]) ? (~in_b + ONE_W) : in_b;

    // acc holds {partial product, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    assign mul_sum_s    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                          (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
    assign div_trial_s  = {1'b0, acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]} - {2'b00, opnd_q};
    assign prod_s       = neg_q ? (~acc_q + ONE_2W) : acc_q;

    assign busy          = (state_q != S_IDLE);
    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_rw        = rw_q;
    assign out_reg_write = reg_write_q;
    assign out_zero      = zero_q;
    assign out_ovf       = ovf_q;
    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;

    // Single-cycle result, overflow, write enable and redirect for the presented instruction.
    always_comb begin
        alu_result_s = {DATA_W{1'b0}};
        alu_ovf_s    = 1'b0;
        alu_write_s  = 1'b1;
        redir_s      = 1'b0;
        redir_pc_s   = {PC_W{1'b0}};
        case (in_op)
            OP_ADD: begin
                alu_result_s = add_sum_s;
                alu_ovf_s    = (in_a[DATA_W-1] == in_b[DATA_W-1]) &
                               (add_sum_s[DATA_W-1] != in_a[DATA_W-1]);
            end
            OP_SUB: begin
                alu_result_s = sub_diff_s;
                alu_ovf_s    = (in_a[DATA_W-1] == sub_b_s[DATA_W-1]) &
                               (sub_diff_s[DATA_W-1] != in_a[DATA_W-1]);
            end
            OP_AND:  alu_result_s = in_a & in_b;
            OP_OR:   alu_result_s = in_a | in_b;
            OP_XOR:  alu_result_s = in_a ^ in_b;
            OP_NOR:  alu_result_s = ~(in_a | in_b);
            OP_SLT:  alu_result_s = {{(DATA_W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: alu_result_s = {{(DATA_W-1){1'b0}}, (in_a < in_b)};
            OP_SLL:  alu_result_s = in_b << in_shamt;
            OP_SRL:  alu_result_s = in_b >> in_shamt;
            OP_SRA:  alu_result_s = $signed(in_b) >>> in_shamt;
            OP_LUI:  alu_result_s = {in_b[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
            OP_MFHI: alu_result_s = hi_q;
            OP_MFLO: alu_result_s = lo_q;
            default: begin
                alu_result_s = {DATA_W{1'b0}};
                alu_write_s  = 1'b0;
            end
        endcase
        if (in_jump) begin
            redir_s      = 1'b1;
            redir_pc_s   = jmp_target_s;
            alu_result_s = {DATA_W{1'b0}};
            alu_ovf_s    = 1'b0;
            alu_write_s  = 1'b0;
        end else if (br_active_s) begin
            redir_s      = br_taken_s;
            redir_pc_s   = br_taken_s ? br_target_s : {PC_W{1'b0}};
            alu_result_s = {DATA_W{1'b0}};
            alu_ovf_s    = 1'b0;
            alu_write_s  = 1'b0;
        end else begin
            redir_s      = 1'b0;
            redir_pc_s   = {PC_W{1'b0}};
        end
    end

    // FSM next state, iterative multiply/divide step and output-register loading.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        cnt_d         = cnt_q;
        neg_d         = neg_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        out_valid_d   = out_valid_q & ~out_ready;
        result_d      = result_q;
        rw_d          = rw_q;
        reg_write_d   = reg_write_q;
        zero_d        = zero_q;
        ovf_d         = ovf_q;
        redirect_d    = redirect_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (xfer_s) begin
                    if (is_multi_s) begin
                        cnt_d       = {CNT_W{1'b0}};
                        out_valid_d = 1'b0;
                        if (in_op == OP_DIVU) begin
                            state_d = S_DIV;
                            acc_d   = {{DATA_W{1'b0}}, in_a};
                            opnd_d  = in_b;
                            neg_d   = 1'b0;
                        end else begin
                            state_d = S_MUL;
                            acc_d   = {{DATA_W{1'b0}}, mag_b_s};
                            opnd_d  = mag_a_s;
                            neg_d   = (in_op == OP_MULT) & (in_a[DATA_W-1] ^ in_b[DATA_W-1]);
                        end
                    end else begin
                        out_valid_d   = 1'b1;
                        result_d      = alu_result_s;
                        rw_d          = in_rw;
                        reg_write_d   = alu_write_s & in_reg_write & (in_rw != {REG_ADDR_W{1'b0}});
                        zero_d        = (alu_result_s == {DATA_W{1'b0}});
                        ovf_d         = alu_ovf_s;
                        redirect_d    = redir_s;
                        redirect_pc_d = redir_pc_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q != LAST_STEP) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (state_q == S_MUL) begin
                        acc_d = {mul_sum_s, acc_q[DATA_W-1:1]};
                    end else if (!div_trial_s[DATA_W+1]) begin
                        acc_d = {div_trial_s[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                    end
                end else if (out_free_s) begin
                    // neg_q is 0 for DIVU, so prod_s is the raw {remainder, quotient}.
                    hi_d          = prod_s[2*DATA_W-1:DATA_W];
                    lo_d          = prod_s[DATA_W-1:0];
                    state_d       = S_IDLE;
                    out_valid_d   = 1'b1;
                    result_d      = {DATA_W{1'b0}};
                    rw_d          = {REG_ADDR_W{1'b0}};
                    reg_write_d   = 1'b0;
                    zero_d        = 1'b1;
                    ovf_d         = 1'b0;
                    redirect_d    = 1'b0;
                    redirect_pc_d = {PC_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            acc_q         <= {(2*DATA_W){1'b0}};
            opnd_q        <= {DATA_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            neg_q         <= 1'b0;
            hi_q          <= {DATA_W{1'b0}};
            lo_q          <= {DATA_W{1'b0}};
            out_valid_q   <= 1'b0;
            result_q      <= {DATA_W{1'b0}};
            rw_q          <= {REG_ADDR_W{1'b0}};
            reg_write_q   <= 1'b0;
            zero_q        <= 1'b0;
            ovf_q         <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= {PC_W{1'b0}};
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            cnt_q         <= cnt_d;
            neg_q         <= neg_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            rw_q          <= rw_d;
            reg_write_q   <= reg_write_d;
            zero_q        <= zero_d;
            ovf_q         <= ovf_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Directed bench for execute_stage_pipe: table of single-cycle vectors plus
// hand-written sequences for multiply/divide, reset mid-operation and backpressure.
module tb_execute_stage_pipe;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_LUI   = 5'd11;
    localparam logic [4:0] OP_MULT  = 5'd12;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        in_valid, in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_a, in_b, in_imm, in_pc4;
    logic [4:0]  in_shamt;
    logic [1:0]  in_branch;
    logic        in_jump;
    logic [25:0] in_jindex;
    logic [4:0]  in_rw;
    logic        in_reg_write;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rw;
    logic        out_reg_write, out_zero, out_ovf, redirect, busy;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [4:0]  shamt;
        logic [31:0] imm, pc4;
        logic [1:0]  branch;
        logic        jump;
        logic [25:0] jindex;
        logic [4:0]  rw;
        logic        rwe;
        logic [31:0] e_res;
        logic        e_wr, e_zero, e_ovf, e_redir;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vq[$];

    execute_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt), .in_imm(in_imm), .in_pc4(in_pc4),
        .in_branch(in_branch), .in_jump(in_jump), .in_jindex(in_jindex),
        .in_rw(in_rw), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rw(out_rw), .out_reg_write(out_reg_write), .out_zero(out_zero), .out_ovf(out_ovf),
        .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sh, input logic [4:0] rw, input logic rwe,
                                    input logic [31:0] res, input logic wr, input logic zero,
                                    input logic ovf);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.shamt = sh; v.imm = 32'h0; v.pc4 = 32'h0;
        v.branch = 2'b00; v.jump = 1'b0; v.jindex = 26'h0; v.rw = rw; v.rwe = rwe;
        v.e_res = res; v.e_wr = wr; v.e_zero = zero; v.e_ovf = ovf;
        v.e_redir = 1'b0; v.e_rpc = 32'h0;
        return v;
    endfunction

    function automatic vec_t mk_br(input logic [1:0] br, input logic jmp, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc4,
                                   input logic [25:0] jidx, input logic redir, input logic [31:0] rpc);
        vec_t v;
        v = mk_alu(OP_SUB, a, b, 5'd0, 5'd9, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        v.branch = br; v.jump = jmp; v.imm = imm; v.pc4 = pc4; v.jindex = jidx;
        v.e_redir = redir; v.e_rpc = rpc;
        return v;
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rw, input logic rwe);
        in_op = op; in_a = a; in_b = b; in_rw = rw; in_reg_write = rwe;
        in_shamt = 5'd0; in_imm = 32'h0; in_pc4 = 32'h0; in_branch = 2'b00;
        in_jump = 1'b0; in_jindex = 26'h0; in_valid = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        @(negedge CLK);
        in_op = v.op; in_a = v.a; in_b = v.b; in_shamt = v.shamt; in_imm = v.imm; in_pc4 = v.pc4;
        in_branch = v.branch; in_jump = v.jump; in_jindex = v.jindex; in_rw = v.rw;
        in_reg_write = v.rwe; in_valid = 1'b1;
        #1;
        check({nm, " in_ready"}, in_ready, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        check({nm, " out_valid"}, out_valid, 1'b1);
        check({nm, " result"}, out_result, v.e_res);
        check({nm, " reg_write"}, out_reg_write, v.e_wr);
        check({nm, " zero"}, out_zero, v.e_zero);
        check({nm, " ovf"}, out_ovf, v.e_ovf);
        check({nm, " redirect"}, redirect, v.e_redir);
        if (v.e_wr) check({nm, " rw"}, out_rw, v.rw);
        if (v.e_redir) check({nm, " redirect_pc"}, redirect_pc, v.e_rpc);
    endtask

    // Multi-cycle op, then MFLO presented while busy, then MFHI.
    task automatic run_multi(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string nm);
        int lat;
        int low;
        @(negedge CLK);
        drive(op, a, b, 5'd0, 1'b0);
        #1;
        check({nm, " accept"}, in_ready, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        drive(OP_MFLO, 32'h0, 32'h0, 5'd8, 1'b1);
        check({nm, " busy"}, busy, 1'b1);
        lat = 0;
        low = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            if (in_ready === 1'b0) low++;
            @(posedge CLK);
            @(negedge CLK);
            lat++;
        end
        check({nm, " latency"}, lat, 33);
        check({nm, " in_ready low cycles"}, low, lat);
        check({nm, " done result"}, out_result, 32'h0);
        check({nm, " done reg_write"}, out_reg_write, 1'b0);
        check({nm, " done busy"}, busy, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        check({nm, " MFLO valid"}, out_valid, 1'b1);
        check({nm, " LO"}, out_result, exp_lo);
        check({nm, " MFLO reg_write"}, out_reg_write, 1'b1);
        in_op = OP_MFHI;
        @(posedge CLK);
        @(negedge CLK);
        check({nm, " HI"}, out_result, exp_hi);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] bp_exp [4];
        int sent;
        int got;
        int cyc;
        logic fire_in;
        logic fire_out;

        RST_N = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_op = 5'd0; in_a = 32'h0; in_b = 32'h0; in_shamt = 5'd0;
        in_imm = 32'h0; in_pc4 = 32'h0; in_branch = 2'b00; in_jump = 1'b0;
        in_jindex = 26'h0; in_rw = 5'd0; in_reg_write = 1'b0;

        vq.push_back(mk_alu(OP_ADD,  32'h7FFFFFFF, 32'h1, 5'd0, 5'd3, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1));
        vq.push_back(mk_alu(OP_SUB,  32'h5, 32'h5, 5'd0, 5'd4, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk_alu(OP_AND,  32'hF0F000FF, 32'h0FF00F0F, 5'd0, 5'd5, 1'b1, 32'h00F0000F, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_OR,   32'hF0F000FF, 32'h0FF00F0F, 5'd0, 5'd5, 1'b1, 32'hFFF00FFF, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_XOR,  32'hF0F000FF, 32'h0FF00F0F, 5'd0, 5'd5, 1'b1, 32'hFF000FF0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_NOR,  32'h0, 32'h0, 5'd0, 5'd6, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_SLT,  32'hFFFFFFFF, 32'h1, 5'd0, 5'd7, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, 5'd7, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk_alu(OP_SLT,  32'h1, 32'hFFFFFFFF, 5'd0, 5'd7, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk_alu(OP_SLL,  32'h0, 32'h1, 5'd31, 5'd8, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_SRL,  32'h0, 32'h80000000, 5'd4, 5'd8, 1'b1, 32'h08000000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_SRA,  32'h0, 32'h80000000, 5'd4, 5'd8, 1'b1, 32'hF8000000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_LUI,  32'h0, 32'h00001234, 5'd0, 5'd9, 1'b1, 32'h12340000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_ADD,  32'h1, 32'h2, 5'd0, 5'd0, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_ADD,  32'h2, 32'h2, 5'd0, 5'd5, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk_alu(OP_SUB,  32'h80000000, 32'h1, 5'd0, 5'd10, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1));
        vq.push_back(mk_alu(OP_ADD,  32'hFFFFFFFF, 32'h1, 5'd0, 5'd11, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk_alu(5'd20,   32'h5, 32'h6, 5'd0, 5'd7, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk_br(2'b01, 1'b0, 32'h4, 32'h4, 32'hFFFFFFFE, 32'h100, 26'h0, 1'b1, 32'hF8));
        vq.push_back(mk_br(2'b10, 1'b0, 32'h4, 32'h4, 32'hFFFFFFFE, 32'h100, 26'h0, 1'b0, 32'h0));
        vq.push_back(mk_br(2'b01, 1'b1, 32'h4, 32'h4, 32'h10, 32'h10000004, 26'h40, 1'b1, 32'h10000100));
        vq.push_back(mk_alu(OP_ADD,  32'h2, 32'h3, 5'd0, 5'd6, 1'b1, 32'h5, 1'b1, 1'b0, 1'b0));
        vq[vq.size()-1].branch = 2'b11;

        // Power-on reset
        repeat (3) @(negedge CLK);
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready", in_ready, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset result", out_result, 32'h0);
        check("reset redirect", redirect, 1'b0);
        RST_N = 1'b1;
        @(negedge CLK);
        check("post-reset in_ready", in_ready, 1'b1);

        foreach (vq[i]) apply_vec(vq[i], $sformatf("vec%0d", i));

        run_multi(OP_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 32'hFFFFFFFF, "MULT -3*7");
        run_multi(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, "DIVU 100/7");
        run_multi(OP_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, "DIVU 9/0");

        // Reset asserted five cycles into a MULT
        @(negedge CLK);
        drive(OP_MULT, 32'h3, 32'h5, 5'd0, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        check("rst-mid busy before", busy, 1'b1);
        repeat (4) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("rst-mid out_valid", out_valid, 1'b0);
        check("rst-mid busy", busy, 1'b0);
        check("rst-mid in_ready", in_ready, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("rst-rel in_ready", in_ready, 1'b1);
        check("rst-rel busy", busy, 1'b0);
        check("rst-rel out_valid", out_valid, 1'b0);
        apply_vec(mk_alu(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd2, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0), "rst LO");
        apply_vec(mk_alu(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd2, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0), "rst HI");

        // Backpressure: four ADDs, out_ready low for three cycles after the first result
        bp_exp[0] = 32'h11; bp_exp[1] = 32'h22; bp_exp[2] = 32'h33; bp_exp[3] = 32'h44;
        @(negedge CLK);
        out_ready = 1'b0;
        drive(OP_ADD, 32'h10, 32'h1, 5'd9, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        drive(OP_ADD, 32'h20, 32'h2, 5'd9, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp hold%0d valid", k), out_valid, 1'b1);
            check($sformatf("bp hold%0d result", k), out_result, 32'h11);
            check($sformatf("bp hold%0d in_ready", k), in_ready, 1'b0);
            @(posedge CLK);
            @(negedge CLK);
        end
        out_ready = 1'b1;
        #1;
        sent = 1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 20) begin
            fire_out = out_valid & out_ready;
            fire_in  = in_valid & in_ready;
            if (fire_out) begin
                check($sformatf("bp result%0d", got), out_result, bp_exp[got]);
                got++;
            end
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
            if (fire_in) begin
                sent++;
                if (sent < 4) drive(OP_ADD, 32'h10 * (sent + 1), sent + 1, 5'd9, 1'b1);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("bp results collected", got, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
